// File: rtl/riscv_irq_stim_pkg.sv
// Shared types and constants for the interrupt stimulus block.
//   mode_e      : generator mode encoding driven on mode_i (3 behaves as OFF)
//   state_e     : request FSM states
//   LFSR_TAPS   : Galois feedback mask for the right-shifting 32-bit LFSR
//   mode_active : true for the modes that launch requests
package riscv_irq_stim_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_RANDOM   = 2'd1,
    MODE_ONE_SHOT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_REQ,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic mode_active(input logic [1:0] m);
    return (m == MODE_RANDOM) || (m == MODE_ONE_SHOT);
  endfunction

endpackage

// File: rtl/riscv_irq_stim_if.sv
// Level-sensitive interrupt handshake between the stimulus block and the core.
//   irq        : interrupt request, held until a matching ack
//   irq_id     : requested interrupt ID, stable while irq=1
//   irq_ack    : core acknowledges an interrupt
//   irq_ack_id : ID the core acknowledges
// master = interrupt source (stimulus), slave = core.
interface riscv_irq_stim_if;
  logic       irq;
  logic [4:0] irq_id;
  logic       irq_ack;
  logic [4:0] irq_ack_id;

  modport master (output irq, irq_id, input irq_ack, irq_ack_id);
  modport slave  (input irq, irq_id, output irq_ack, irq_ack_id);
endinterface

// File: rtl/riscv_irq_lfsr.sv
// 32-bit right-shifting Galois LFSR with enable, seed load and zero-seed guard.
//   clk, rst  : clock, synchronous active-high reset (loads SEED_DEFAULT)
//   enable    : advance one step this cycle
//   seed_load : load seed this cycle (wins over advancing); seed 0 loads 1
//   seed      : seed value
//   value     : current LFSR state
module riscv_irq_lfsr
  import riscv_irq_stim_pkg::*;
#(
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        seed_load,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= SEED_DEFAULT;
    end else if (seed_load) begin
      // An all-zero state would lock the LFSR up.
      value <= (seed == '0) ? 32'd1 : seed;
    end else if (enable) begin
      value <= {1'b0, value[31:1]} ^ (value[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/riscv_irq_stim.sv
// Interrupt stimulus source for the core test harness.
// Launches random or one-shot interrupts after an LFSR-drawn gap, holds each
// request until the core acks it with the matching ID, and flags protocol
// errors and ack timeouts.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   enable_i, mode_i    : generator enable and mode (OFF/RANDOM/ONE_SHOT)
//   seed_load_i, seed_i : LFSR seed load
//   min_gap_i/gap_mask_i: base gap and random gap mask
//   id_base_i/id_mask_i : base ID and random ID mask
//   bus                 : irq handshake (master side)
//   irq_count_o         : accepted acks (wraps)
//   err_o, timeout_o    : sticky protocol error / ack timeout
module riscv_irq_stim
  import riscv_irq_stim_pkg::*;
#(
  parameter int unsigned GAP_W        = 16,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter logic [31:0] SEED_DEFAULT = 32'h0000_0001
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [1:0]       mode_i,
  input  logic             seed_load_i,
  input  logic [31:0]      seed_i,
  input  logic [GAP_W-1:0] min_gap_i,
  input  logic [GAP_W-1:0] gap_mask_i,
  input  logic [4:0]       id_base_i,
  input  logic [4:0]       id_mask_i,
  riscv_irq_stim_if.master bus,
  output logic [31:0]      irq_count_o,
  output logic             err_o,
  output logic             timeout_o
);

  localparam int unsigned      TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0]  TO_MAX = TO_W'(TIMEOUT_CYC);

  state_e           state;
  logic [31:0]      lfsr;
  logic [GAP_W-1:0] gap_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             irq_q;
  logic [4:0]       irq_id_q;
  logic             one_shot_q;
  logic [GAP_W-1:0] gap_draw;
  logic [4:0]       id_draw;
  logic             ack_valid;
  logic             lfsr_unused;

  riscv_irq_lfsr #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_lfsr (
    .clk       (clk_i),
    .rst       (rst_i),
    .enable    (enable_i),
    .seed_load (seed_load_i),
    .seed      (seed_i),
    .value     (lfsr)
  );

  // Only a slice of the LFSR feeds the draws.
  assign lfsr_unused = ^lfsr;

  always_comb begin
    gap_draw = min_gap_i;
    id_draw  = id_base_i;
    if (mode_i != MODE_ONE_SHOT) begin
      gap_draw = min_gap_i + (lfsr[GAP_W-1:0] & gap_mask_i);
      id_draw  = id_base_i + (lfsr[20:16] & id_mask_i);
    end
  end

  assign ack_valid  = bus.irq_ack && (bus.irq_ack_id == irq_id_q);
  assign bus.irq    = irq_q;
  assign bus.irq_id = irq_id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
      one_shot_q  <= 1'b0;
      irq_count_o <= '0;
      err_o       <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      if (bus.irq_ack && (state != ST_REQ)) begin
        err_o <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (enable_i && mode_active(mode_i)) begin
            state      <= ST_COUNT;
            gap_cnt    <= gap_draw;
            irq_id_q   <= id_draw;
            // Remember the launching mode: a pending request outlives mode
            // changes, and its ack decides between IDLE and DONE.
            one_shot_q <= (mode_i == MODE_ONE_SHOT);
          end
        end
        ST_COUNT: begin
          if (!enable_i || !mode_active(mode_i)) begin
            state <= ST_IDLE;
          end else if (gap_cnt == '0) begin
            state  <= ST_REQ;
            irq_q  <= 1'b1;
            to_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_valid) begin
            irq_q       <= 1'b0;
            irq_count_o <= irq_count_o + 32'd1;
            state       <= one_shot_q ? ST_DONE : ST_IDLE;
          end else begin
            if (bus.irq_ack) begin
              err_o <= 1'b1;
            end
            if (to_cnt != TO_MAX) begin
              to_cnt <= to_cnt + 1'b1;
              if (to_cnt + 1'b1 == TO_MAX) begin
                timeout_o <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (!enable_i || (mode_i != MODE_ONE_SHOT)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
